// File: rtl/ram_backend_pkg.sv
// Shared types and helpers for the ram_backend backing-store model.
//   state_e      : controller states (INIT, IDLE, WAIT, RESP)
//   CNT_W        : width of the access-latency counter (covers LATENCY 1..15)
//   init_pattern : power-up contents of one array word
package ram_backend_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Word written to address 'addr' during self-initialisation; callers
  // truncate the result to their data width.
  function automatic logic [31:0] init_pattern(input logic [31:0] addr,
                                               input logic [31:0] xor_val);
    return addr ^ xor_val;
  endfunction

endpackage

// File: rtl/bk_mem_array.sv
// Storage array for ram_backend: one synchronous write port and one
// combinational read port. Contents are not reset; the controller
// re-patterns the array after every reset.
//   clk   : clock, rising edge
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
module bk_mem_array #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Single write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Asynchronous read port.
  assign rdata = mem[raddr];

endmodule

// File: rtl/ram_backend.sv
// Backing store behind the direct-mapped cache. Serves one read or write
// request at a time with a programmable latency, and fills the array with
// a deterministic pattern after every reset before accepting traffic.
//   clk       : clock, rising edge
//   rst       : synchronous reset, active high
//   req_valid : request present
//   req_ready : request can be accepted (only while idle)
//   req_we    : 1 = write, 0 = read
//   req_addr  : request address
//   req_wdata : write data
//   rsp_valid : response present
//   rsp_ready : consumer takes the response
//   rsp_rdata : read data, or echoed write data for writes
//   init_done : array initialisation complete
module ram_backend
  import ram_backend_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       DATA_W   = 8,
  parameter int unsigned       LATENCY  = 3,
  parameter logic [DATA_W-1:0] INIT_XOR = DATA_W'(8'hA5)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              init_done
);

  localparam logic             LAT_ONE  = (LATENCY == 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_e            state;
  logic [ADDR_W-1:0] ptr;
  logic [CNT_W-1:0]  cnt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              accept_c;
  logic              exec_c;
  logic              acc_we_c;
  logic [ADDR_W-1:0] acc_addr_c;
  logic [DATA_W-1:0] acc_wdata_c;
  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_waddr_c;
  logic [DATA_W-1:0] mem_wdata_c;
  logic [DATA_W-1:0] mem_rdata_c;
  logic [DATA_W-1:0] rsp_data_c;

  // Request handshake; req_ready is only ever high in IDLE.
  assign accept_c = (state == ST_IDLE) && req_valid && req_ready;

  // The access executes on the edge where the latency count runs out: the
  // accept edge itself for a single-cycle build, otherwise the WAIT edge on
  // which the counter steps from 1 to 0. Either way rsp_valid is seen high
  // LATENCY cycles after the cycle in which the request was accepted.
  assign exec_c = (accept_c && LAT_ONE) ||
                  ((state == ST_WAIT) && (cnt == CNT_W'(1)));

  // Access operands come straight from the request when executing on the
  // accept edge, otherwise from the latched copy.
  always_comb begin
    acc_we_c    = req_we;
    acc_addr_c  = req_addr;
    acc_wdata_c = req_wdata;
    if (state == ST_WAIT) begin
      acc_we_c    = we_q;
      acc_addr_c  = addr_q;
      acc_wdata_c = wdata_q;
    end
  end

  // Array write port shared by the init sweep and write requests; held off
  // during reset so an access cut short by reset never commits.
  always_comb begin
    mem_we_c    = 1'b0;
    mem_waddr_c = acc_addr_c;
    mem_wdata_c = acc_wdata_c;
    if (!rst) begin
      if (state == ST_INIT) begin
        mem_we_c    = 1'b1;
        mem_waddr_c = ptr;
        mem_wdata_c = DATA_W'(init_pattern(32'(ptr), 32'(INIT_XOR)));
      end else if (exec_c && acc_we_c) begin
        mem_we_c = 1'b1;
      end
    end
  end

  // Writes echo their data; reads return the current array word.
  assign rsp_data_c = acc_we_c ? acc_wdata_c : mem_rdata_c;

  bk_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we_c),
    .waddr (mem_waddr_c),
    .wdata (mem_wdata_c),
    .raddr (acc_addr_c),
    .rdata (mem_rdata_c)
  );

  // Controller: init sweep, request latch, latency count, response hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_INIT;
      ptr       <= '0;
      cnt       <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          ptr <= ptr + ADDR_W'(1);
          if (ptr == '1) begin
            state     <= ST_IDLE;
            init_done <= 1'b1;
            req_ready <= 1'b1;
          end
        end

        ST_IDLE: begin
          if (accept_c) begin
            we_q      <= req_we;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            cnt       <= CNT_LOAD;
            req_ready <= 1'b0;
            if (exec_c) begin
              rsp_valid <= 1'b1;
              rsp_rdata <= rsp_data_c;
              state     <= ST_RESP;
            end else begin
              state <= ST_WAIT;
            end
          end
        end

        ST_WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (exec_c) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= rsp_data_c;
            state     <= ST_RESP;
          end
        end

        ST_RESP: begin
          // rsp_rdata is left untouched so it keeps its value afterwards.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_INIT;
        end
      endcase
    end
  end

endmodule
